spi_slave_core: RTL and testbench

SPI responder for the bus-mapped SPI master: it receives the master's SCLK/SDI/SEN, captures the incoming bit stream into an RX buffer and returns a preloaded TX buffer on SDO. It oversamples all SPI inputs on BUS_CLK, so it needs no second clock domain. Firmware reaches it through a register and memory map on the IP-side bus, like any other core behind bus_to_ip. Its main use is as an on-chip loopback or emulation target for spi-based device models and for self-tests.

---
 rtl/spi_slave_core.sv | 135 +++++++++++++
 tb/tb_spi_slave_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI mode-0 responder oversampled on BUS_CLK, with bus-mapped TX/RX byte buffers and
// frame status registers.
module spi_slave_core #(
    parameter int unsigned ABUSWIDTH = 16,
    parameter int unsigned MEM_BYTES = 2
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 SCLK,
    input  logic                 SDI,
    input  logic                 SEN,
    output logic                 SDO,
    output logic                 FRAME_DONE
);
    localparam int unsigned IW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [15:0] NBits = 16'(MEM_BYTES * 8);
    localparam logic [ABUSWIDTH-1:0] TxBase = ABUSWIDTH'(16);
    localparam logic [ABUSWIDTH-1:0] RxBase = ABUSWIDTH'(16 + MEM_BYTES);
    localparam logic [ABUSWIDTH-1:0] RxEnd = ABUSWIDTH'(16 + 2 * MEM_BYTES);

    logic [7:0]  tx_mem [MEM_BYTES];
    logic [7:0]  rx_mem [MEM_BYTES];
    logic [2:0]  sclk_s, sen_s;
    logic [1:0]  sdi_s;
    logic [15:0] bitcnt_q, last_cnt_q;
    logic        busy_q, done_q, overrun_q, sdo_q, frame_done_q;
    logic [7:0]  rd_data_q, rd_mux;

    logic          soft_rst, stat_clr, tx_wr, in_range;
    logic          sclk_rise, sclk_fall, sen_rise, sen_fall;
    logic [IW-1:0] byte_idx;
    logic [2:0]    bit_idx;

    assign soft_rst  = BUS_WR && (BUS_ADD == '0);
    assign stat_clr  = BUS_WR && (BUS_ADD == ABUSWIDTH'(1));
    assign tx_wr     = BUS_WR && (BUS_ADD >= TxBase) && (BUS_ADD < RxBase);
    // SCLK edges and the SEN fall only count inside an accepted frame.
    assign sclk_rise = busy_q && sclk_s[1] && !sclk_s[2];
    assign sclk_fall = busy_q && !sclk_s[1] && sclk_s[2];
    assign sen_rise  = sen_s[1] && !sen_s[2];
    assign sen_fall  = busy_q && !sen_s[1] && sen_s[2];
    assign in_range  = bitcnt_q < NBits;
    assign byte_idx  = bitcnt_q[IW+2:3];
    assign bit_idx   = 3'd7 - bitcnt_q[2:0];

    always_comb begin
        rd_mux = 8'h00;
        if (BUS_ADD == '0) begin
            rd_mux = 8'd1;
        end else if (BUS_ADD == ABUSWIDTH'(1)) begin
            rd_mux = {5'b0, overrun_q, busy_q, done_q};
        end else if (BUS_ADD == ABUSWIDTH'(2)) begin
            rd_mux = last_cnt_q[7:0];
        end else if (BUS_ADD == ABUSWIDTH'(3)) begin
            rd_mux = last_cnt_q[15:8];
        end else if ((BUS_ADD >= TxBase) && (BUS_ADD < RxBase)) begin
            rd_mux = tx_mem[IW'(BUS_ADD - TxBase)];
        end else if ((BUS_ADD >= RxBase) && (BUS_ADD < RxEnd)) begin
            rd_mux = rx_mem[IW'(BUS_ADD - RxBase)];
        end
    end

    // SEN sync chain resets high so a frame already running at reset release has no rise.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            sclk_s       <= '0;
            sen_s        <= '1;
            sdi_s        <= '0;
            bitcnt_q     <= '0;
            last_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            sdo_q        <= 1'b0;
            frame_done_q <= 1'b0;
            rd_data_q    <= '0;
        end else if (soft_rst) begin
            sclk_s       <= '0;
            sen_s        <= '1;
            sdi_s        <= '0;
            bitcnt_q     <= '0;
            last_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            sdo_q        <= 1'b0;
            frame_done_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            sclk_s       <= {sclk_s[1:0], SCLK};
            sen_s        <= {sen_s[1:0], SEN};
            sdi_s        <= {sdi_s[0], SDI};
            frame_done_q <= 1'b0;
            // Clear first so a coincident set below wins.
            if (stat_clr) begin
                done_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (sen_rise) begin
                bitcnt_q <= '0;
                busy_q   <= 1'b1;
                sdo_q    <= tx_mem[0][7];
            end
            if (sclk_rise) begin
                if (!in_range) overrun_q <= 1'b1;
                if (bitcnt_q != 16'hFFFF) bitcnt_q <= bitcnt_q + 16'd1;
            end
            if (sclk_fall) begin
                sdo_q <= in_range ? tx_mem[byte_idx][bit_idx] : 1'b0;
            end
            if (sen_fall) begin
                last_cnt_q   <= bitcnt_q;
                done_q       <= 1'b1;
                frame_done_q <= 1'b1;
                busy_q       <= 1'b0;
                sdo_q        <= 1'b0;
            end
            if (BUS_RD) rd_data_q <= rd_mux;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (tx_wr) tx_mem[IW'(BUS_ADD - TxBase)] <= BUS_DATA_IN;
        if (sclk_rise && in_range && !soft_rst) rx_mem[byte_idx][bit_idx] <= sdi_s[1];
    end

    assign BUS_DATA_OUT = rd_data_q;
    assign SDO          = sdo_q;
    assign FRAME_DONE   = frame_done_q;
endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: an SPI master model plus bus tasks; register reads are
// checked by a monitor popping an expected-value queue.
module tb_spi_slave_core;
    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic [15:0] BUS_ADD;
    logic [7:0]  BUS_DATA_IN;
    logic        BUS_RD, BUS_WR;
    logic [7:0]  BUS_DATA_OUT;
    logic        SCLK, SDI, SEN, SDO, FRAME_DONE;

    int          checks = 0;
    int          errors = 0;
    int          fd_cnt = 0;
    logic [31:0] miso;
    string       name_q[$];
    logic [7:0]  val_q[$];

    spi_slave_core #(
        .ABUSWIDTH(16),
        .MEM_BYTES(2)
    ) dut (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST     (BUS_RST),
        .BUS_ADD     (BUS_ADD),
        .BUS_DATA_IN (BUS_DATA_IN),
        .BUS_RD      (BUS_RD),
        .BUS_WR      (BUS_WR),
        .BUS_DATA_OUT(BUS_DATA_OUT),
        .SCLK        (SCLK),
        .SDI         (SDI),
        .SEN         (SEN),
        .SDO         (SDO),
        .FRAME_DONE  (FRAME_DONE)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge BUS_CLK);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        BUS_ADD = a;
        BUS_DATA_IN = d;
        BUS_WR = 1'b1;
        wait_cyc(1);
        BUS_WR = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input string name);
        name_q.push_back(name);
        val_q.push_back(e);
        BUS_ADD = a;
        BUS_RD = 1'b1;
        wait_cyc(1);
        BUS_RD = 1'b0;
        wait_cyc(1);
    endtask

    task automatic spi_begin();
        miso = '0;
        SEN = 1'b1;
        wait_cyc(6);
    endtask

    // Master drives SDI while SCLK is low and samples SDO on the rising edge.
    task automatic spi_bits(input logic [31:0] mosi, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            SDI = mosi[i];
            wait_cyc(5);
            SCLK = 1'b1;
            miso = {miso[30:0], SDO};
            wait_cyc(5);
            SCLK = 1'b0;
        end
    endtask

    task automatic spi_end();
        wait_cyc(6);
        SEN = 1'b0;
        wait_cyc(6);
    endtask

    // Read-data monitor: a read strobe seen at a rising edge presents data by the next low phase.
    initial begin
        logic seen;
        forever begin
            @(posedge BUS_CLK);
            seen = BUS_RD;
            @(negedge BUS_CLK);
            if (seen) begin
                if (name_q.size() == 0) begin
                    check("unexpected_read", {24'h0, BUS_DATA_OUT}, 32'hFFFF_FFFF);
                end else begin
                    check(name_q.pop_front(), {24'h0, BUS_DATA_OUT}, {24'h0, val_q.pop_front()});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge BUS_CLK);
            if (FRAME_DONE === 1'b1) fd_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        BUS_RST = 1'b1;
        BUS_ADD = '0;
        BUS_DATA_IN = '0;
        BUS_RD = 1'b0;
        BUS_WR = 1'b0;
        SCLK = 1'b0;
        SDI = 1'b0;
        SEN = 1'b0;
        wait_cyc(3);
        BUS_RST = 1'b0;
        wait_cyc(2);
        check("rst_data_out", {24'h0, BUS_DATA_OUT}, 32'h0);
        check("rst_sdo", {31'h0, SDO}, 32'h0);
        check("rst_frame_done", {31'h0, FRAME_DONE}, 32'h0);
        bus_read(16'd1, 8'h00, "rst_status");
        bus_read(16'd2, 8'h00, "rst_last_cnt");

        // Loopback
        bus_write(16'd16, 8'hA5);
        bus_write(16'd17, 8'h3C);
        spi_begin();
        spi_bits(32'hC3F0, 16);
        spi_end();
        check("loop_sdo", miso, 32'h0000_A53C);
        check("loop_frame_done", fd_cnt, 1);
        bus_read(16'd18, 8'hC3, "loop_rx0");
        bus_read(16'd19, 8'hF0, "loop_rx1");
        bus_read(16'd2, 8'd16, "loop_last_lo");
        bus_read(16'd3, 8'h00, "loop_last_hi");
        bus_read(16'd1, 8'h01, "loop_status");

        // Partial frame over an all-ones RX
        spi_begin();
        spi_bits(32'hFFFF, 16);
        spi_end();
        check("fill_sdo", miso, 32'h0000_A53C);
        spi_begin();
        spi_bits(32'h000, 12);
        spi_end();
        check("part_sdo", miso, 32'h0000_0A53);
        bus_read(16'd18, 8'h00, "part_rx0");
        bus_read(16'd19, 8'h0F, "part_rx1");
        bus_read(16'd2, 8'd12, "part_last_lo");
        bus_read(16'd1, 8'h01, "part_status");

        // Overrun
        spi_begin();
        spi_bits(32'h12345, 20);
        spi_end();
        check("ovr_sdo", miso, 32'h000A_53C0);
        check("ovr_frame_done", fd_cnt, 4);
        bus_read(16'd18, 8'h12, "ovr_rx0");
        bus_read(16'd19, 8'h34, "ovr_rx1");
        bus_read(16'd2, 8'd20, "ovr_last_lo");
        bus_read(16'd1, 8'h05, "ovr_status");
        bus_write(16'd1, 8'h00);
        bus_read(16'd1, 8'h00, "ovr_status_clr");

        // Live TX update after four bits
        bus_write(16'd17, 8'h00);
        spi_begin();
        spi_bits(32'h0, 4);
        bus_write(16'd17, 8'hFF);
        spi_bits(32'h0, 12);
        spi_end();
        check("live_sdo", miso, 32'h0000_A5FF);
        bus_read(16'd1, 8'h01, "live_status");

        // Reset mid-frame
        spi_begin();
        spi_bits(32'h1F, 5);
        BUS_RST = 1'b1;
        wait_cyc(2);
        BUS_RST = 1'b0;
        wait_cyc(1);
        check("midrst_sdo", {31'h0, SDO}, 32'h0);
        check("midrst_data_out", {24'h0, BUS_DATA_OUT}, 32'h0);
        spi_bits(32'h7, 3);
        bus_read(16'd1, 8'h00, "midrst_status");
        spi_end();
        check("midrst_no_done", fd_cnt, 5);
        bus_read(16'd2, 8'h00, "midrst_last_lo");
        spi_begin();
        spi_bits(32'h9E21, 16);
        spi_end();
        check("clean_sdo", miso, 32'h0000_A5FF);
        check("clean_frame_done", fd_cnt, 6);
        bus_read(16'd2, 8'd16, "clean_last_lo");
        bus_read(16'd18, 8'h9E, "clean_rx0");
        bus_read(16'd19, 8'h21, "clean_rx1");

        // Register edge cases
        bus_read(16'd0, 8'h01, "version");
        bus_read(16'd4, 8'h00, "reserved4");
        bus_write(16'd18, 8'h55);
        bus_read(16'd18, 8'h9E, "rx_write_ignored");
        bus_read(16'd40, 8'h00, "above_range");
        bus_write(16'd1, 8'h00);
        bus_read(16'd1, 8'h00, "pre_coinc_status");

        // Status clear in the same cycle the SEN fall is acted on
        spi_begin();
        spi_bits(32'h0, 16);
        wait_cyc(6);
        SEN = 1'b0;
        wait_cyc(2);
        BUS_ADD = 16'd1;
        BUS_DATA_IN = 8'h00;
        BUS_WR = 1'b1;
        wait_cyc(1);
        BUS_WR = 1'b0;
        wait_cyc(6);
        bus_read(16'd1, 8'h01, "coinc_done_wins");

        // Soft reset keeps memories
        bus_write(16'd0, 8'h00);
        bus_read(16'd1, 8'h00, "soft_status");
        bus_read(16'd2, 8'h00, "soft_last_lo");
        bus_read(16'd16, 8'hA5, "soft_tx0_kept");
        bus_read(16'd19, 8'h00, "soft_rx1_kept");

        wait_cyc(4);
        check("queue_drain", name_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
